bound_flasher_ctrl: RTL and testbench

- 16-lamp "bound flasher" controller, driven by a single FLICK pushbutton.
- A FLICK pulse while idle starts a fixed light sequence on a thermometer-coded LED bar: on to lamp 5, off to 0, on to 10, off to 5, on to 15, off to 0.
- Holding FLICK at kickback points (lamp 5 or lamp 10 lit while rising) sends the bar back down, and that leg repeats.
- Sits between a debounced button/clock domain and a 16-LED display driver.

---
 rtl/bound_flasher_ctrl.sv | 149 ++++++++++++++
 tb/tb_bound_flasher_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bound_flasher_ctrl
// Description : 16-lamp bound flasher. A FLICK in idle launches a fixed
//               thermometer-coded light sequence. Holding FLICK while the bar
//               is rising past lamp 5 or lamp 10 sends it back down, and that
//               leg repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module bound_flasher_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLICK,
  output logic [15:0] LED
);

  // Sequence legs. Each rising leg climbs toward a peak and each falling leg
  // drains toward a valley.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP5   = 3'd1,
    ST_DN0   = 3'd2,
    ST_UP10  = 3'd3,
    ST_DN5   = 3'd4,
    ST_UP15  = 3'd5,
    ST_DNEND = 3'd6
  } state_t;

  // Bar patterns at which the sequence turns around or may kick back.
  localparam logic [15:0] C_LVL_NONE = 16'h0000;  // all lamps off
  localparam logic [15:0] C_LVL_4    = 16'h001F;  // lamps 0..4 on
  localparam logic [15:0] C_LVL_5    = 16'h003F;  // lamps 0..5 on
  localparam logic [15:0] C_LVL_10   = 16'h07FF;  // lamps 0..10 on
  localparam logic [15:0] C_LVL_15   = 16'hFFFF;  // lamps 0..15 on
  localparam logic [15:0] C_LVL_0    = 16'h0001;  // first lamp only

  state_t      r_state;
  logic [15:0] r_led;

  logic [15:0] w_shift_in;
  logic [15:0] w_shift_out;
  logic        w_at_5;
  logic        w_at_10;

  // Candidate next bar values: light one more lamp, or drop the top lamp.
  assign w_shift_in  = {r_led[14:0], 1'b1};
  assign w_shift_out = {1'b0, r_led[15:1]};

  // Kickback check points on the way up.
  assign w_at_5  = (r_led == C_LVL_5);
  assign w_at_10 = (r_led == C_LVL_10);

  assign LED = r_led;

  // Sequence controller: advances the bar one lamp per clock and picks the
  // next leg from the pre-edge bar value and FLICK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_led   <= C_LVL_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (FLICK) begin
            r_led   <= C_LVL_0;
            r_state <= ST_UP5;
          end else begin
            r_led   <= C_LVL_NONE;
          end
        end

        // First climb: no kickback possible, FLICK is ignored.
        ST_UP5: begin
          if (w_at_5) begin
            r_led   <= w_shift_out;
            r_state <= ST_DN0;
          end else begin
            r_led   <= w_shift_in;
          end
        end

        // Drain to empty, then start the climb toward lamp 10.
        ST_DN0: begin
          if (r_led == C_LVL_NONE) begin
            r_led   <= w_shift_in;
            r_state <= ST_UP10;
          end else begin
            r_led   <= w_shift_out;
          end
        end

        // Climb to lamp 10; a held FLICK at lamp 5 or lamp 10 repeats the
        // drain to empty instead of the normal drain to lamp 4.
        ST_UP10: begin
          if (w_at_10) begin
            r_led   <= w_shift_out;
            r_state <= FLICK ? ST_DN0 : ST_DN5;
          end else if (w_at_5 && FLICK) begin
            r_led   <= w_shift_out;
            r_state <= ST_DN0;
          end else begin
            r_led   <= w_shift_in;
          end
        end

        // Drain down to lamp 4, then climb to the top.
        ST_DN5: begin
          if (r_led == C_LVL_4) begin
            r_led   <= w_shift_in;
            r_state <= ST_UP15;
          end else begin
            r_led   <= w_shift_out;
          end
        end

        // Climb to the top; a held FLICK at lamp 5 or lamp 10 repeats the
        // drain to lamp 4.
        ST_UP15: begin
          if (r_led == C_LVL_15) begin
            r_led   <= w_shift_out;
            r_state <= ST_DNEND;
          end else if (FLICK && (w_at_5 || w_at_10)) begin
            r_led   <= w_shift_out;
            r_state <= ST_DN5;
          end else begin
            r_led   <= w_shift_in;
          end
        end

        // Final drain; the empty bar is held while returning to idle.
        ST_DNEND: begin
          if (r_led == C_LVL_NONE) begin
            r_state <= ST_IDLE;
          end else begin
            r_led   <= w_shift_out;
          end
        end

        // Unused encoding: recover to a clean idle.
        default: begin
          r_state <= ST_IDLE;
          r_led   <= C_LVL_NONE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bound_flasher_ctrl
// Description : Self-checking bench for bound_flasher_ctrl. A lamp-count /
//               leg-table model predicts the bar on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bound_flasher_ctrl;

  logic        CLK;
  logic        RST;
  logic        FLICK;
  logic [15:0] LED;

  int total;
  int bad;

  bound_flasher_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .FLICK (FLICK),
    .LED   (LED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: number of lit lamps plus the index of the current leg
  // of the journey (-1 = idle). Legs alternate rising/falling toward a
  // target lamp count.
  int m_n;
  int m_leg;

  function automatic int leg_target(input int leg);
    case (leg)
      0:       return 6;
      1:       return 0;
      2:       return 11;
      3:       return 5;
      4:       return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] exp_led();
    logic [16:0] t;
    t = (17'd1 << m_n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic model_step(input logic f);
    bit kick;
    if (m_leg < 0) begin
      if (f) begin
        m_n   = 1;
        m_leg = 0;
      end
    end else if ((m_leg % 2) == 0) begin
      // rising leg; legs 2 and 4 allow going back one leg at 6 or 11 lamps
      kick = f && (m_leg != 0) && (m_n == 6 || m_n == 11);
      if (m_n == leg_target(m_leg) || kick) begin
        m_n   = m_n - 1;
        m_leg = kick ? m_leg - 1 : m_leg + 1;
      end else begin
        m_n = m_n + 1;
      end
    end else begin
      if (m_n == leg_target(m_leg)) begin
        if (m_leg == 5) m_leg = -1;
        else begin
          m_n   = m_n + 1;
          m_leg = m_leg + 1;
        end
      end else begin
        m_n = m_n - 1;
      end
    end
  endtask

  // Drive FLICK, let one rising edge pass, advance the model, sample after.
  task automatic tick(input logic f);
    FLICK = f;
    @(posedge CLK);
    model_step(f);
    #1;
  endtask

  // Put DUT and model in idle (no checking here).
  task automatic hard_reset();
    RST   = 1'b1;
    FLICK = 1'b0;
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    m_n   = 0;
    m_leg = -1;
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    FLICK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (LED !== 16'h0000) begin
      bad++;
      $display("FAIL reset_value got=%h want=%h", LED, 16'h0000);
    end
    RST   = 1'b0;
    m_n   = 0;
    m_leg = -1;
    repeat (3) begin
      tick(1'b0);
      total++;
      if (LED !== 16'h0000) begin
        bad++;
        $display("FAIL idle_hold got=%h want=%h", LED, 16'h0000);
      end
    end
  endtask

  task automatic test_normal();
    int          tc[7] = '{1, 6, 12, 23, 29, 40, 56};
    logic [15:0] tv[7] = '{16'h0001, 16'h003F, 16'h0000, 16'h07FF,
                           16'h001F, 16'hFFFF, 16'h0000};
    hard_reset();
    for (int c = 1; c <= 60; c++) begin
      // start at c1, ignored flick at c53, fresh start at c60 proves idle
      tick((c == 1) || (c == 53) || (c == 60));
      total++;
      if (LED !== exp_led()) begin
        bad++;
        $display("FAIL normal_flow cyc=%0d got=%h want=%h", c, LED, exp_led());
      end
      for (int k = 0; k < 7; k++) begin
        if (tc[k] == c) begin
          total++;
          if (LED !== tv[k]) begin
            bad++;
            $display("FAIL normal_table cyc=%0d got=%h want=%h", c, LED, tv[k]);
          end
        end
      end
    end
    total++;
    if (LED !== 16'h0001) begin
      bad++;
      $display("FAIL restart_after_idle got=%h want=%h", LED, 16'h0001);
    end
  endtask

  task automatic test_async_reset();
    int where[3] = '{30, 37, 45};
    for (int w = 0; w < 3; w++) begin
      hard_reset();
      for (int c = 1; c <= where[w]; c++) begin
        tick(c == 1);
        total++;
        if (LED !== exp_led()) begin
          bad++;
          $display("FAIL pre_reset cyc=%0d got=%h want=%h", c, LED, exp_led());
        end
      end
      #2 RST = 1'b1;
      #1;
      total++;
      if (LED !== 16'h0000) begin
        bad++;
        $display("FAIL async_reset cyc=%0d got=%h want=%h", where[w], LED, 16'h0000);
      end
      m_n   = 0;
      m_leg = -1;
      #2 RST = 1'b0;
      tick(1'b0);
      total++;
      if (LED !== 16'h0000) begin
        bad++;
        $display("FAIL post_reset_idle got=%h want=%h", LED, 16'h0000);
      end
      tick(1'b1);
      total++;
      if (LED !== 16'h0001) begin
        bad++;
        $display("FAIL post_reset_start got=%h want=%h", LED, 16'h0001);
      end
    end
  endtask

  // FLICK at the lamp-10 peak: in UP10 (edge 24) and in UP15 (edge 36).
  task automatic test_kickbacks();
    int kick_edge[2] = '{24, 36};
    for (int k = 0; k < 2; k++) begin
      hard_reset();
      for (int c = 1; c <= 90; c++) begin
        tick((c == 1) || (c == kick_edge[k]));
        total++;
        if (LED !== exp_led()) begin
          bad++;
          $display("FAIL kickback%0d cyc=%0d got=%h want=%h", k, c, LED, exp_led());
        end
        if (c == kick_edge[k]) begin
          total++;
          if (LED !== 16'h03FF) begin
            bad++;
            $display("FAIL kick_turn%0d got=%h want=%h", k, LED, 16'h03FF);
          end
        end
        // UP10 kick drains to empty by edge 34; UP15 kick bottoms at lamp 4
        if ((k == 0 && c == 34) || (k == 1 && c == 41)) begin
          total++;
          if (LED !== (k == 0 ? 16'h0000 : 16'h001F)) begin
            bad++;
            $display("FAIL kick_valley%0d got=%h want=%h", k, LED,
                     (k == 0 ? 16'h0000 : 16'h001F));
          end
        end
      end
    end
  endtask

  // Toggling FLICK only in legs where it must be ignored.
  task automatic test_invalid_flicks();
    int          tc[7] = '{1, 6, 12, 23, 29, 40, 56};
    logic [15:0] tv[7] = '{16'h0001, 16'h003F, 16'h0000, 16'h07FF,
                           16'h001F, 16'hFFFF, 16'h0000};
    logic f;
    hard_reset();
    for (int c = 1; c <= 58; c++) begin
      if (c == 1) f = 1'b1;
      else if ((c >= 2 && c <= 13) || (c >= 25 && c <= 30) || (c >= 42 && c <= 56))
        f = c[0];
      else f = 1'b0;
      tick(f);
      total++;
      if (LED !== exp_led()) begin
        bad++;
        $display("FAIL invalid_flick cyc=%0d got=%h want=%h", c, LED, exp_led());
      end
      for (int k = 0; k < 7; k++) begin
        if (tc[k] == c) begin
          total++;
          if (LED !== tv[k]) begin
            bad++;
            $display("FAIL invalid_table cyc=%0d got=%h want=%h", c, LED, tv[k]);
          end
        end
      end
    end
  endtask

  // FLICK held for edges 17..20 covers the lamp-5 check in UP10 (edge 19).
  task automatic test_long_flick();
    hard_reset();
    for (int c = 1; c <= 70; c++) begin
      tick((c == 1) || (c >= 17 && c <= 20));
      total++;
      if (LED !== exp_led()) begin
        bad++;
        $display("FAIL long_flick cyc=%0d got=%h want=%h", c, LED, exp_led());
      end
      // kick at 19 -> empty at 24 -> climb from 25 -> peak 0x07FF at 35
      if (c == 19 || c == 24 || c == 35) begin
        total++;
        if (LED !== (c == 19 ? 16'h001F : (c == 24 ? 16'h0000 : 16'h07FF))) begin
          bad++;
          $display("FAIL long_flick_pt cyc=%0d got=%h", c, LED);
        end
      end
    end
  endtask

  task automatic test_reset_with_flick();
    hard_reset();
    RST   = 1'b1;
    FLICK = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (LED !== 16'h0000) begin
      bad++;
      $display("FAIL rst_flick_hold got=%h want=%h", LED, 16'h0000);
    end
    RST   = 1'b0;
    FLICK = 1'b0;
    m_n   = 0;
    m_leg = -1;
    tick(1'b0);
    total++;
    if (LED !== 16'h0000) begin
      bad++;
      $display("FAIL rst_flick_release got=%h want=%h", LED, 16'h0000);
    end
    tick(1'b1);
    total++;
    if (LED !== 16'h0001) begin
      bad++;
      $display("FAIL rst_flick_start got=%h want=%h", LED, 16'h0001);
    end
  endtask

  task automatic test_random();
    logic f;
    hard_reset();
    for (int c = 1; c <= 1500; c++) begin
      f = ($urandom_range(0, 3) == 0);
      tick(f);
      total++;
      if (LED !== exp_led()) begin
        bad++;
        $display("FAIL random cyc=%0d flick=%0b got=%h want=%h", c, f, LED, exp_led());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_n   = 0;
    m_leg = -1;
    RST   = 1'b1;
    FLICK = 1'b0;
    test_reset();
    test_normal();
    test_async_reset();
    test_kickbacks();
    test_invalid_flicks();
    test_long_flick();
    test_reset_with_flick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
